// File: rtl/scoreboard_regfile_pkg.sv
// Shared CPU types: register word and register index.
// Defaults for the integer register file and its scoreboard.
package scoreboard_regfile_pkg;
    localparam int WORD_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REGIDX_W = $clog2(NUM_REGS);

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [REGIDX_W-1:0] regidx_t;
endpackage

// File: rtl/scoreboard_regfile_wr_arbiter.sv
// Same-cycle write match for one read index.
// Highest write port wins; index 0 never hits.
module regfile_wr_arbiter
    import scoreboard_regfile_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int SEL_W  = REGIDX_W,
    parameter int NWR    = 2
) (
    input  logic [SEL_W-1:0]           sel,
    input  logic [NWR-1:0]             wen,
    input  logic [NWR-1:0][SEL_W-1:0]  wsel,
    input  logic [NWR-1:0][DATA_W-1:0] wdat,
    output logic                       hit,
    output logic [DATA_W-1:0]          dat
);

    always_comb begin
        hit = 1'b0;
        dat = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wen[p] && (wsel[p] == sel) && (sel != '0)) begin
                hit = 1'b1;
                dat = wdat[p];
            end
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port register file with write-through bypass
// and a per-register busy scoreboard.
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int NREGS  = NUM_REGS,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    localparam int SEL_W = $clog2(NREGS)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NWR-1:0]             wen,
    input  logic [NWR-1:0][SEL_W-1:0]  wsel,
    input  logic [NWR-1:0][DATA_W-1:0] wdat,
    input  logic [NRD-1:0][SEL_W-1:0]  rsel,
    output logic [NRD-1:0][DATA_W-1:0] rdat,
    output logic [NRD-1:0]             rbusy,
    input  logic                       issue_en,
    input  logic [SEL_W-1:0]           issue_sel,
    input  logic                       flush,
    output logic [NREGS-1:0]           busy_vec
);

    logic [DATA_W-1:0]          regs [NREGS];
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_nxt;
    logic [NRD-1:0]             hit;
    logic [NRD-1:0][DATA_W-1:0] bdat;

    // Ascending port order: the last assignment (highest port) wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && (wsel[p] != '0)) begin
                    regs[wsel[p]] <= wdat[p];
                end
            end
        end
    end

    // Clear on write, then set on issue, then flush overrides all.
    always_comb begin
        busy_nxt = busy;
        for (int p = 0; p < NWR; p++) begin
            if (wen[p]) begin
                busy_nxt[wsel[p]] = 1'b0;
            end
        end
        if (issue_en && (issue_sel != '0)) begin
            busy_nxt[issue_sel] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    for (genvar q = 0; q < NRD; q++) begin : g_rd
        regfile_wr_arbiter #(
            .DATA_W (DATA_W),
            .SEL_W  (SEL_W),
            .NWR    (NWR)
        ) u_arb (
            .sel  (rsel[q]),
            .wen  (wen),
            .wsel (wsel),
            .wdat (wdat),
            .hit  (hit[q]),
            .dat  (bdat[q])
        );

        assign rdat[q] = !nRST  ? '0 :
                         hit[q] ? bdat[q] :
                                  regs[rsel[q]];

        assign rbusy[q] = nRST & busy[rsel[q]] & ~hit[q];
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: vector table
// plus hand-written reset sequences.
module tb_scoreboard_regfile;

    logic            CLK;
    logic            nRST;
    logic [1:0]      wen;
    logic [1:0][4:0] wsel;
    logic [1:0][31:0] wdat;
    logic [1:0][4:0] rsel;
    logic [1:0][31:0] rdat;
    logic [1:0]      rbusy;
    logic            issue_en;
    logic [4:0]      issue_sel;
    logic            flush;
    logic [31:0]     busy_vec;

    int errors = 0;
    int checks = 0;

    scoreboard_regfile dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .wen       (wen),
        .wsel      (wsel),
        .wdat      (wdat),
        .rsel      (rsel),
        .rdat      (rdat),
        .rbusy     (rbusy),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  ws0;
        logic [31:0] wd0;
        logic [4:0]  ws1;
        logic [31:0] wd1;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        iss;
        logic [4:0]  isel;
        logic        fl;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  erb;
        logic [31:0] ebv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] w, input logic [4:0] s0,
                       input logic [31:0] d0, input logic [4:0] s1,
                       input logic [31:0] d1, input logic [4:0] r0,
                       input logic [4:0] r1, input logic is,
                       input logic [4:0] isl, input logic f,
                       input logic [31:0] x0, input logic [31:0] x1,
                       input logic [1:0] xrb, input logic [31:0] xbv);
        vec_t v;
        v.wen = w;  v.ws0 = s0; v.wd0 = d0; v.ws1 = s1; v.wd1 = d1;
        v.rs0 = r0; v.rs1 = r1; v.iss = is; v.isel = isl; v.fl = f;
        v.e0 = x0;  v.e1 = x1;  v.erb = xrb; v.ebv = xbv;
        vecs.push_back(v);
    endtask

    task automatic idle();
        wen = '0; wsel = '0; wdat = '0; rsel = '0;
        issue_en = 1'b0; issue_sel = '0; flush = 1'b0;
    endtask

    initial begin
        //   wen  ws0 wd0          ws1 wd1    rs0 rs1 iss isel fl  e0           e1           rb     bv
        add(2'b01, 5, 32'hDEADBEEF, 0, 0,      5,  0,  0, 0,  0, 32'hDEADBEEF, 0,           2'b00, 0);
        add(2'b00, 0, 0,            0, 0,      5,  0,  0, 0,  0, 32'hDEADBEEF, 0,           2'b00, 0);
        add(2'b01, 0, 32'hFFFFFFFF, 0, 0,      0,  0,  0, 0,  0, 0,            0,           2'b00, 0);
        add(2'b00, 0, 0,            0, 0,      0,  5,  0, 0,  0, 0,            32'hDEADBEEF, 2'b00, 0);
        add(2'b11, 7, 32'h11,       7, 32'h22, 7,  7,  0, 0,  0, 32'h22,       32'h22,      2'b00, 0);
        add(2'b00, 0, 0,            0, 0,      5,  7,  0, 0,  0, 32'hDEADBEEF, 32'h22,      2'b00, 0);
        add(2'b00, 0, 0,            0, 0,      9,  0,  1, 9,  0, 0,            0,           2'b00, 32'h200);
        add(2'b00, 0, 0,            0, 0,      9,  0,  0, 0,  0, 0,            0,           2'b01, 32'h200);
        add(2'b01, 9, 32'h55,       0, 0,      9,  0,  0, 0,  0, 32'h55,       0,           2'b00, 0);
        add(2'b10, 0, 0,            3, 32'h33, 3,  0,  1, 3,  0, 32'h33,       0,           2'b00, 32'h8);
        add(2'b00, 0, 0,            0, 0,      3,  9,  0, 0,  0, 32'h33,       32'h55,      2'b01, 32'h8);
        add(2'b00, 0, 0,            0, 0,      0,  0,  1, 2,  0, 0,            0,           2'b00, 32'hC);
        add(2'b00, 0, 0,            0, 0,      0,  0,  1, 4,  0, 0,            0,           2'b00, 32'h1C);
        add(2'b00, 0, 0,            0, 0,      2,  6,  1, 6,  0, 0,            0,           2'b01, 32'h5C);
        add(2'b01, 12, 32'hC0FFEE,  0, 0,      12, 4,  1, 8,  1, 32'hC0FFEE,   0,           2'b10, 0);
        add(2'b00, 0, 0,            0, 0,      12, 4,  0, 0,  0, 32'hC0FFEE,   0,           2'b00, 0);
        add(2'b00, 0, 0,            0, 0,      0,  0,  1, 0,  0, 0,            0,           2'b00, 0);
        add(2'b11, 1, 32'hAAAA,     1, 32'hBBBB, 1, 3, 0, 0,  0, 32'hBBBB,     32'h33,      2'b00, 0);

        // Reset with an active write aimed at the read index.
        idle();
        nRST = 1'b0;
        wen = 2'b01; wsel[0] = 5; wdat[0] = 32'h12345678;
        rsel[0] = 5; issue_en = 1'b1; issue_sel = 5;
        #1;
        chk("rst_rdat0", rdat[0], 32'h0);
        chk("rst_rbusy", {30'b0, rbusy}, 32'h0);
        chk("rst_busy_vec", busy_vec, 32'h0);
        @(posedge CLK); #1;
        chk("rst_hold_rdat0", rdat[0], 32'h0);
        chk("rst_hold_busy_vec", busy_vec, 32'h0);
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        @(posedge CLK); #1;

        foreach (vecs[i]) begin
            wen = vecs[i].wen;
            wsel[0] = vecs[i].ws0; wdat[0] = vecs[i].wd0;
            wsel[1] = vecs[i].ws1; wdat[1] = vecs[i].wd1;
            rsel[0] = vecs[i].rs0; rsel[1] = vecs[i].rs1;
            issue_en = vecs[i].iss; issue_sel = vecs[i].isel;
            flush = vecs[i].fl;
            @(negedge CLK);
            chk($sformatf("v%0d_rdat0", i), rdat[0], vecs[i].e0);
            chk($sformatf("v%0d_rdat1", i), rdat[1], vecs[i].e1);
            chk($sformatf("v%0d_rbusy", i), {30'b0, rbusy},
                {30'b0, vecs[i].erb});
            @(posedge CLK); #1;
            chk($sformatf("v%0d_busy_vec", i), busy_vec, vecs[i].ebv);
        end

        // Busy r10 holding 0xA5, then reset between edges.
        idle();
        wen = 2'b01; wsel[0] = 10; wdat[0] = 32'hA5;
        @(posedge CLK); #1;
        idle();
        issue_en = 1'b1; issue_sel = 10;
        @(posedge CLK); #1;
        idle();
        rsel[0] = 10;
        #1;
        chk("pre_rst_rdat10", rdat[0], 32'hA5);
        chk("pre_rst_busy_vec", busy_vec, 32'h400);
        chk("pre_rst_rbusy", {30'b0, rbusy}, 32'h1);
        nRST = 1'b0;
        #1;
        chk("async_rst_busy_vec", busy_vec, 32'h0);
        chk("async_rst_rdat10", rdat[0], 32'h0);
        chk("async_rst_rbusy", {30'b0, rbusy}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("post_rst_r10", rdat[0], 32'h0);

        // First edge after reset release works normally.
        wen = 2'b10; wsel[1] = 11; wdat[1] = 32'h77;
        issue_en = 1'b1; issue_sel = 11;
        @(posedge CLK); #1;
        idle();
        rsel[1] = 11;
        #1;
        chk("post_rst_wr_r11", rdat[1], 32'h77);
        chk("post_rst_busy_vec", busy_vec, 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
